// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-port arbiter and sequencer for the shared data memory
//
// Port 0 (pipeline MEM stage) has priority over port 1 (loader/dump port).
// A starvation counter forces a port-1 win after STARVE_MAX consecutive
// port-0 grants made while port 1 was waiting.
//
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   p0_req/we/addr/wdata          port-0 request (MEM stage)
//   p0_rdata, p0_ack, p0_stall    port-0 response; stall = req & ~ack
//   p1_req/we/addr/wdata          port-1 request (loader)
//   p1_rdata, p1_ack              port-1 response
//   mem_en/we/addr/wdata          registered memory strobe and command
//   mem_rdata                     memory read data, valid MEM_LAT cycles after mem_en
module dmem_arbiter #(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          p0_req,
  input  logic          p0_we,
  input  logic [AW-1:0] p0_addr,
  input  logic [DW-1:0] p0_wdata,
  output logic [DW-1:0] p0_rdata,
  output logic          p0_ack,
  output logic          p0_stall,
  input  logic          p1_req,
  input  logic          p1_we,
  input  logic [AW-1:0] p1_addr,
  input  logic [DW-1:0] p1_wdata,
  output logic [DW-1:0] p1_rdata,
  output logic          p1_ack,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  localparam int SW = $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t        state;
  logic [SW-1:0] starve;
  logic [1:0]    cnt;
  logic          grant;   // 1 = port 1 owns the current access
  logic          pick1;

  assign pick1    = p1_req && (!p0_req || (starve == SW'(STARVE_MAX)));
  assign p0_stall = p0_req & ~p0_ack;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      starve    <= '0;
      cnt       <= '0;
      grant     <= 1'b0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      p0_ack    <= 1'b0;
      p1_ack    <= 1'b0;
      p0_rdata  <= '0;
      p1_rdata  <= '0;
    end else begin
      mem_en <= 1'b0;
      p0_ack <= 1'b0;
      p1_ack <= 1'b0;
      unique case (state)
        IDLE: begin
          if (!p1_req) starve <= '0;
          // The ack cycle is spent in IDLE without arbitrating: the winner's
          // req is still high there and must not be taken as a new request.
          if (!(p0_ack || p1_ack) && (p0_req || p1_req)) begin
            grant     <= pick1;
            mem_we    <= pick1 ? p1_we    : p0_we;
            mem_addr  <= pick1 ? p1_addr  : p0_addr;
            mem_wdata <= pick1 ? p1_wdata : p0_wdata;
            mem_en    <= 1'b1;
            state     <= ISSUE;
            if (pick1)
              starve <= '0;
            else if (p1_req && (starve != SW'(STARVE_MAX)))
              starve <= starve + SW'(1);
          end
        end
        ISSUE: begin
          cnt   <= 2'(MEM_LAT - 1);
          state <= (MEM_LAT == 1) ? DONE : WAIT;
        end
        WAIT: begin
          cnt <= cnt - 2'd1;
          if (cnt == 2'd1) state <= DONE;
        end
        DONE: begin
          if (grant) begin
            p1_ack <= 1'b1;
            if (!mem_we) p1_rdata <= mem_rdata;
          end else begin
            p0_ack <= 1'b1;
            if (!mem_we) p0_rdata <= mem_rdata;
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - scoreboard bench for dmem_arbiter (MEM_LAT=1 and MEM_LAT=3 instances)
module tb_dmem_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst   [2];
  logic        req   [2][2];
  logic        we    [2][2];
  logic [31:0] addr  [2][2];
  logic [31:0] wdata [2][2];
  logic [31:0] rdata [2][2];
  logic        ack   [2][2];
  logic        stall0 [2];
  logic        mem_en [2];
  logic        mem_we [2];
  logic [31:0] mem_addr  [2];
  logic [31:0] mem_wdata [2];
  logic [31:0] mem_rdata [2];

  int checks = 0;
  int passes = 0;

  // Scoreboard queues indexed inst*2+port, reference memory and last read per port.
  logic [31:0] sbq [4][$];
  logic [31:0] refmem  [2][256];
  logic [31:0] last_rd [2][2];
  int          glog    [2][$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_inst
    localparam int LAT = (g == 0) ? 1 : 3;
    logic [31:0] mem  [256];
    logic [31:0] pipe [LAT];
    logic        en_prev = 1'b0;
    logic [31:0] e_q;

    dmem_arbiter #(.AW(32), .DW(32), .MEM_LAT(LAT), .STARVE_MAX(4)) dut (
      .clk(clk), .rst(rst[g]),
      .p0_req(req[g][0]), .p0_we(we[g][0]), .p0_addr(addr[g][0]), .p0_wdata(wdata[g][0]),
      .p0_rdata(rdata[g][0]), .p0_ack(ack[g][0]), .p0_stall(stall0[g]),
      .p1_req(req[g][1]), .p1_we(we[g][1]), .p1_addr(addr[g][1]), .p1_wdata(wdata[g][1]),
      .p1_rdata(rdata[g][1]), .p1_ack(ack[g][1]),
      .mem_en(mem_en[g]), .mem_we(mem_we[g]), .mem_addr(mem_addr[g]),
      .mem_wdata(mem_wdata[g]), .mem_rdata(mem_rdata[g])
    );

    assign mem_rdata[g] = pipe[LAT-1];

    initial for (int k = 0; k < 256; k++) mem[k] = 32'h0;

    // Memory with LAT-cycle read latency; poison data when not enabled.
    always @(posedge clk) begin
      if (mem_en[g]) begin
        if (mem_we[g]) mem[mem_addr[g][9:2]] <= mem_wdata[g];
        pipe[0] <= mem[mem_addr[g][9:2]];
      end else begin
        pipe[0] <= 32'hBADBADBA;
      end
      for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
    end

    // Monitor: pops expected rdata on every ack, checks cycle invariants.
    always @(negedge clk) begin
      if (!rst[g]) begin
        if (ack[g][0] && ack[g][1]) chk($sformatf("dual_ack i%0d", g), 32'd1, 32'd0);
        if (en_prev && mem_en[g]) chk($sformatf("mem_en_b2b i%0d", g), 32'd1, 32'd0);
        if (stall0[g] !== (req[g][0] & ~ack[g][0]))
          chk($sformatf("p0_stall i%0d", g), 32'(stall0[g]), 32'(req[g][0] & ~ack[g][0]));
        for (int p = 0; p < 2; p++) begin
          if (ack[g][p]) begin
            glog[g].push_back(p);
            if (sbq[g*2+p].size() == 0) begin
              chk($sformatf("unexpected_ack i%0d p%0d", g, p), 32'd1, 32'd0);
            end else begin
              e_q = sbq[g*2+p].pop_front();
              chk($sformatf("rdata i%0d p%0d", g, p), rdata[g][p], e_q);
            end
          end
        end
      end
      en_prev <= mem_en[g];
    end
  end

  // One request, held until ack. lat>0 also checks timing relative to the sample edge.
  task automatic do_op(input int i, input int p, input logic w, input logic [31:0] a,
                       input logic [31:0] d, input int lat);
    int k, stalls, ens;
    logic [31:0] e;
    if (w) begin
      refmem[i][a[9:2]] = d;
      e = last_rd[i][p];
    end else begin
      e = refmem[i][a[9:2]];
      last_rd[i][p] = e;
    end
    sbq[i*2+p].push_back(e);
    we[i][p] = w; addr[i][p] = a; wdata[i][p] = d; req[i][p] = 1'b1;
    k = 0; stalls = 0; ens = 0;
    while (k < 80) begin
      @(negedge clk);
      k++;
      if (p == 0 && stall0[i]) stalls++;
      if (mem_en[i]) ens++;
      if (ack[i][p]) break;
    end
    if (!ack[i][p]) chk($sformatf("ack_timeout i%0d p%0d", i, p), 32'd0, 32'd1);
    else if (lat > 0) begin
      chk($sformatf("latency i%0d p%0d", i, p), 32'(k - 1), 32'(lat));
      chk($sformatf("mem_en_pulses i%0d p%0d", i, p), 32'(ens), 32'd1);
      if (p == 0) chk($sformatf("stall_cycles i%0d", i), 32'(stalls), 32'(lat));
    end
    @(posedge clk); #1;
    req[i][p] = 1'b0;
  endtask

  task automatic check_zero(input int i, input string tag);
    chk({tag, " mem_en"},    32'(mem_en[i]), 32'd0);
    chk({tag, " mem_we"},    32'(mem_we[i]), 32'd0);
    chk({tag, " mem_addr"},  mem_addr[i],    32'd0);
    chk({tag, " mem_wdata"}, mem_wdata[i],   32'd0);
    chk({tag, " p0_ack"},    32'(ack[i][0]), 32'd0);
    chk({tag, " p1_ack"},    32'(ack[i][1]), 32'd0);
    chk({tag, " p0_rdata"},  rdata[i][0],    32'd0);
    chk({tag, " p1_rdata"},  rdata[i][1],    32'd0);
  endtask

  task automatic rand_port(input int i, input int p, input int n);
    logic [31:0] a;
    for (int j = 0; j < n; j++) begin
      repeat ($urandom_range(0, 3)) @(posedge clk);
      a = 32'(p * 32'h200) + 32'($urandom_range(0, 15) << 2);
      do_op(i, p, 1'($urandom_range(0, 1)), a, $urandom, 0);
    end
  endtask

  task automatic cont_port(input int p, input int n);
    for (int j = 0; j < n; j++)
      do_op(0, p, j[0], 32'(p * 32'h200) + 32'(j << 2), 32'hA000_0000 + 32'(j), 0);
  endtask

  int s, expg;

  initial begin
    for (int i = 0; i < 2; i++) begin
      rst[i] = 1'b1;
      for (int p = 0; p < 2; p++) begin
        req[i][p] = 1'b0; we[i][p] = 1'b0; addr[i][p] = '0; wdata[i][p] = '0;
        last_rd[i][p] = '0;
      end
      for (int k = 0; k < 256; k++) refmem[i][k] = '0;
    end
    #12;
    check_zero(0, "reset i0");
    check_zero(1, "reset i1");
    #3;
    rst[0] = 1'b0; rst[1] = 1'b0;
    @(posedge clk); #1;

    // Port-0 write then read, MEM_LAT=1.
    do_op(0, 0, 1'b1, 32'h80, 32'hDEADBEEF, 3);
    do_op(0, 0, 1'b0, 32'h80, 32'h0, 3);
    chk("p0 read 0x80", rdata[0][0], 32'hDEADBEEF);

    // Port 1 only: fill and read back.
    for (int j = 0; j < 16; j++) do_op(0, 1, 1'b1, 32'h80 + 32'(j * 4), 32'(j + 1), 3);
    for (int j = 0; j < 16; j++) do_op(0, 1, 1'b0, 32'h80 + 32'(j * 4), 32'h0, 3);

    // Write must not disturb previously read data.
    do_op(0, 0, 1'b1, 32'h84, 32'h12345678, 3);
    do_op(0, 0, 1'b0, 32'h84, 32'h0, 3);
    do_op(0, 0, 1'b1, 32'h84, 32'hAAAA5555, 3);
    chk("rdata kept after write", rdata[0][0], 32'h12345678);

    // MEM_LAT=3 port-0 access.
    do_op(1, 0, 1'b1, 32'h40, 32'h0BADF00D, 5);
    do_op(1, 0, 1'b0, 32'h40, 32'h0, 5);

    // Both ports requesting continuously: grant order follows the starvation rule.
    glog[0].delete();
    fork
      cont_port(0, 8);
      cont_port(1, 2);
    join
    chk("grant_count", 32'(glog[0].size()), 32'd10);
    s = 0;
    for (int j = 0; j < 10 && j < glog[0].size(); j++) begin
      if (s == 4) begin expg = 1; s = 0; end
      else begin expg = 0; s++; end
      chk($sformatf("grant_order[%0d]", j), 32'(glog[0][j]), 32'(expg));
    end

    // Reset during WAIT of a port-1 write (MEM_LAT=3).
    we[1][1] = 1'b1; addr[1][1] = 32'h300; wdata[1][1] = 32'hCAFE0001; req[1][1] = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (mem_en[1]) break;
    end
    chk("abort mem_en seen", 32'(mem_en[1]), 32'd1);
    @(posedge clk); #1;
    rst[1] = 1'b1;
    #1;
    check_zero(1, "abort");
    req[1][1] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("abort no p1_ack", 32'(ack[1][1]), 32'd0);
    end
    last_rd[1][0] = '0; last_rd[1][1] = '0;
    @(posedge clk); #1;
    rst[1] = 1'b0;
    @(posedge clk); #1;
    do_op(1, 1, 1'b1, 32'h300, 32'hCAFE0002, 5);
    do_op(1, 1, 1'b0, 32'h300, 32'h0, 5);

    // Randomized concurrent traffic on both instances, disjoint regions per port.
    fork
      rand_port(0, 0, 12);
      rand_port(0, 1, 12);
      rand_port(1, 0, 12);
      rand_port(1, 1, 12);
    join
    repeat (4) @(posedge clk);
    for (int q = 0; q < 4; q++) chk($sformatf("sb_drained[%0d]", q), 32'(sbq[q].size()), 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
